// File: rtl/bin_gra.sv
// 4-bit binary<->Gray converter; mode selects direction, optional registered output stage.
// Each output bit is produced by its own lane from the input bit and the bits above it.

module bin_gra_lane (
    input  logic mode,
    input  logic b_in,
    input  logic b_up,
    input  logic up_xor,
    output logic o
);
    // Gray->binary needs the XOR of every input bit above this one; binary->Gray only the next bit up
    assign o = b_in ^ (mode ? up_xor : b_up);
endmodule

module bin_gra #(
    parameter int REGISTERED = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic g3,
    output logic g2,
    output logic g1,
    output logic g0,
    output logic valid,
    output logic par
);
    localparam int W      = 4;
    localparam int STAGES = 1;

    logic [W-1:0] b_vec;
    logic [W:0]   b_ext;
    logic [W:0]   up_xor;
    logic [W-1:0] conv;
    logic         conv_par;
    logic [W-1:0] g_out;
    logic         par_out;
    logic         valid_out;

    assign b_vec = {b3, b2, b1, b0};
    assign b_ext = {1'b0, b_vec};

    // Prefix XOR from the MSB built straight from inputs, so lanes never feed each other
    assign up_xor[W] = 1'b0;
    genvar i;
    generate
        for (i = W - 1; i >= 0; i--) begin : g_pfx
            assign up_xor[i] = up_xor[i+1] ^ b_vec[i];
        end

        for (i = 0; i < W; i++) begin : g_lane
            bin_gra_lane u_lane (
                .mode   (mode),
                .b_in   (b_vec[i]),
                .b_up   (b_ext[i+1]),
                .up_xor (up_xor[i+1]),
                .o      (conv[i])
            );
        end
    endgenerate

    assign conv_par = ^conv;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [STAGES:0] vld_pipe;
            logic [W-1:0]    g_q;
            logic            par_q;

            assign vld_pipe[0] = en;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_q              <= '0;
                    par_q            <= 1'b0;
                    vld_pipe[STAGES:1] <= '0;
                end else begin
                    vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
                    if (en) begin
                        g_q   <= conv;
                        par_q <= conv_par;
                    end
                end
            end

            assign g_out     = g_q;
            assign par_out   = par_q;
            assign valid_out = vld_pipe[STAGES];
        end else begin : g_comb
            assign g_out     = conv;
            assign par_out   = conv_par;
            assign valid_out = en;
        end
    endgenerate

    assign {g3, g2, g1, g0} = g_out;
    assign par              = par_out;
    assign valid            = valid_out;
endmodule

// File: tb/tb_bin_gra.sv
// Directed bench for bin_gra (registered build): reset, both directions, count walk, hold, random round trip.
module tb_bin_gra;
    logic clk, rst_n, en, mode;
    logic b3, b2, b1, b0;
    logic g3, g2, g1, g0, valid, par;
    logic [3:0] g;
    int n_chk  = 0;
    int n_fail = 0;

    assign g = {g3, g2, g1, g0};

    bin_gra #(.REGISTERED(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .b3(b3), .b2(b2), .b1(b1), .b0(b0),
        .g3(g3), .g2(g2), .g1(g1), .g0(g0),
        .valid(valid), .par(par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [3:0] to_bin(input logic [3:0] x);
        logic [3:0] r;
        r[3] = x[3];
        for (int k = 2; k >= 0; k--) r[k] = r[k+1] ^ x[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [3:0] g_exp, input logic v_exp, input logic p_exp);
        n_chk++;
        assert ({g, valid, par} === {g_exp, v_exp, p_exp}) else begin
            n_fail++;
            $error("FAIL %s: got g=%b valid=%b par=%b, want g=%b valid=%b par=%b",
                   tag, g, valid, par, g_exp, v_exp, p_exp);
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] v, input logic e);
        mode = m; {b3, b2, b1, b0} = v; en = e;
    endtask

    // drive, let one edge sample, look 1 ns later
    task automatic step(input logic m, input logic [3:0] v, input logic e);
        drive(m, v, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev, x, gx, held;
        logic       m;
        int         ones;
        logic [3:0] dir_in  [8];
        logic [3:0] dir_out [8];

        dir_in  = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0111, 4'b1000, 4'b1111, 4'b0000};
        dir_out = '{4'b0000, 4'b0111, 4'b1111, 4'b1000, 4'b0101, 4'b1111, 4'b1010, 4'b0000};

        rst_n = 1'b0;
        drive(1'b0, 4'b1111, 1'b1);
        #1 chk("reset_state", 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("reset_held_over_edge", 4'b0000, 1'b0, 1'b0);
        #4 rst_n = 1'b1;
        step(1'b0, 4'b0101, 1'b1);
        chk("first_after_reset", 4'b0111, 1'b1, 1'b1);

        // directed: first four bin->Gray, last four Gray->bin
        for (int k = 0; k < 8; k++) begin
            step(k >= 4, dir_in[k], 1'b1);
            chk($sformatf("directed_%0d", k), dir_out[k], 1'b1, ^dir_out[k]);
        end

        // count walk with wrap 15->0: every step a single-bit Gray change
        step(1'b0, 4'd0, 1'b1);
        prev = g;
        for (int k = 1; k <= 16; k++) begin
            x = k[3:0];
            step(1'b0, x, 1'b1);
            chk($sformatf("count_%0d", k), to_gray(x), 1'b1, ^to_gray(x));
            ones = $countones(prev ^ g);
            n_chk++;
            assert (ones == 1) else begin
                n_fail++;
                $error("FAIL count_onebit_%0d: got %0d bits changed, want 1", k, ones);
            end
            prev = g;
        end

        // hold with en low while inputs move
        step(1'b1, 4'b1011, 1'b1);
        held = 4'b1101;
        chk("hold_load", held, 1'b1, ^held);
        for (int k = 0; k < 3; k++) begin
            step(k[0], 4'(k * 5 + 2), 1'b0);
            chk($sformatf("hold_%0d", k), held, 1'b0, ^held);
        end
        step(1'b0, 4'b0110, 1'b1);
        chk("hold_release", 4'b0101, 1'b1, 1'b0);

        // mid-stream asynchronous reset, no edge between assert and check
        drive(1'b0, 4'b1001, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 4'b0000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_first", 4'b1101, 1'b1, 1'b1);

        // random vectors in both modes, then round trip back to the input
        for (int k = 0; k < 10; k++) begin
            x = 4'($urandom);
            m = 1'($urandom);
            step(m, x, 1'b1);
            chk($sformatf("rand_%0d", k), m ? to_bin(x) : to_gray(x), 1'b1,
                ^(m ? to_bin(x) : to_gray(x)));
            step(1'b0, x, 1'b1);
            gx = g;
            step(1'b1, gx, 1'b1);
            chk($sformatf("roundtrip_%0d", k), x, 1'b1, ^x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, want finish before 50000 ns");
        $fatal(1);
    end
endmodule
